// File: rtl/mux_pkg.sv
// Shared helpers for the pipelined mux tree: tree depth and channel-count legality.
package mux_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Tree reduction only closes cleanly for power-of-two channel counts.
  function automatic bit legal_n(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Valid/ready bus for mux_tree_pipe: N packed channels in, one selected channel plus select echo out.
interface mux_tree_pipe_if import mux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int N     = 8
) ();
  localparam int LEVELS = clog2(N);

  logic [N*WIDTH-1:0]  in_data;
  logic [LEVELS-1:0]   in_sel;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    out_data;
  logic [LEVELS-1:0]   out_sel;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_tree_level.sv
// One registered 2:1 reduction level of the mux tree; halves the channel count.
module mux_tree_level import mux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int IN_CH = 8,
  parameter int SELW  = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [IN_CH-1:0][WIDTH-1:0]       d_i,
  input  logic [SELW-1:0]                   sel_i,
  input  logic                              vld_i,
  output logic [IN_CH/2-1:0][WIDTH-1:0]     d_o,
  output logic [SELW-1:0]                   sel_o,
  output logic                              vld_o
);
  localparam int OUT_CH = IN_CH / 2;
  // Depth of this level in the tree, and thus which select bit it consumes.
  localparam int BIT    = SELW - clog2(IN_CH);

  logic [OUT_CH-1:0][WIDTH-1:0] red;

  always_comb begin
    red = '0;
    for (int j = 0; j < OUT_CH; j++)
      red[j] = sel_i[BIT] ? d_i[2*j+1] : d_i[2*j];
  end

  // The full select travels with the beat; its upper bits steer later levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_o   <= '0;
      sel_o <= '0;
      vld_o <= 1'b0;
    end else if (en) begin
      d_o   <= red;
      sel_o <= sel_i;
      vld_o <= vld_i;
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree, one register per level, global stall enable.
module mux_tree_pipe import mux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             rst,
  mux_tree_pipe_if.slave   bus
);
  localparam int LEVELS = clog2(N);
  localparam int NODES  = 2*N - 1;

  if (!legal_n(N)) begin : g_bad_n
    $error("mux_tree_pipe: N must be a power of two >= 2");
  end

  logic                          adv;
  // All tree nodes, leaves first: level k reads node[2N-2*(N>>k) +: N>>k].
  logic [NODES-1:0][WIDTH-1:0]   node;
  logic [LEVELS:0][LEVELS-1:0]   sel_pipe;
  logic [LEVELS:0]               vld_pipe;

  assign adv          = ~vld_pipe[LEVELS] | bus.out_ready;
  assign bus.in_ready = adv;

  assign node[N-1:0]  = bus.in_data;
  assign sel_pipe[0]  = bus.in_sel;
  assign vld_pipe[0]  = bus.in_valid;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int ICH = N >> k;
    localparam int IB  = 2*N - 2*ICH;
    localparam int OB  = 2*N - ICH;

    mux_tree_level #(
      .WIDTH (WIDTH),
      .IN_CH (ICH),
      .SELW  (LEVELS)
    ) u_lvl (
      .clk   (clk),
      .rst   (rst),
      .en    (adv),
      .d_i   (node[IB +: ICH]),
      .sel_i (sel_pipe[k]),
      .vld_i (vld_pipe[k]),
      .d_o   (node[OB +: ICH/2]),
      .sel_o (sel_pipe[k+1]),
      .vld_o (vld_pipe[k+1])
    );
  end

  assign bus.out_data  = node[NODES-1];
  assign bus.out_sel   = sel_pipe[LEVELS];
  assign bus.out_valid = vld_pipe[LEVELS];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: directed cases plus random valid/ready against a queue model.
module tb_mux_tree_pipe;
  localparam int W = 8;
  localparam int N = 8;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_tree_pipe_if #(.WIDTH(W), .N(N)) bus ();
  mux_tree_pipe #(.WIDTH(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  mux_tree_pipe_if #(.WIDTH(16), .N(2)) bus2 ();
  mux_tree_pipe #(.WIDTH(16), .N(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: the selected channel is simply the sel-th WIDTH-bit slice.
  function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input int s);
    logic [N*W-1:0] t;
    t = d >> (s * W);
    return t[W-1:0];
  endfunction

  logic [W-1:0] q_d[$];
  logic [L-1:0] q_s[$];
  int           n_in = 0, n_out = 0;
  bit           stalled = 0;
  logic [W-1:0] hold_d;
  logic [L-1:0] hold_s;

  // Inputs are set at posedge+1; outputs sampled at posedge+2; then advance one clock.
  task automatic cycle();
    #1;
    if (stalled) begin
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_data", bus.out_data, hold_d);
      chk("hold_sel", bus.out_sel, hold_s);
    end
    if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", bus.in_ready, 1'b0);
    if (bus.out_valid && bus.out_ready) begin
      if (q_d.size() == 0) chk("spurious_beat", 1, 0);
      else begin
        chk("sb_data", bus.out_data, q_d.pop_front());
        chk("sb_sel", bus.out_sel, q_s.pop_front());
      end
      n_out++;
    end
    if (bus.in_valid && bus.in_ready) begin
      q_d.push_back(pick(bus.in_data, int'(bus.in_sel)));
      q_s.push_back(bus.in_sel);
      n_in++;
    end
    stalled = bus.out_valid && !bus.out_ready;
    hold_d  = bus.out_data;
    hold_s  = bus.out_sel;
    @(posedge clk);
    #1;
  endtask

  task automatic ramp_data();
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'(8'h10 + i);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_data = '0; bus.in_sel = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus2.in_data = '0; bus2.in_sel = '0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_sel", bus.out_sel, 3'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    cycle();

    // Single beat, sel=5
    ramp_data();
    bus.out_ready = 1'b1;
    bus.in_sel = 3'd5; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      if (r == L) begin
        chk("single_valid", bus.out_valid, 1'b1);
        chk("single_data", bus.out_data, 8'h15);
        chk("single_sel", bus.out_sel, 3'd5);
      end else chk("single_idle", bus.out_valid, 1'b0);
      cycle();
    end

    // Full sweep, back-to-back
    for (int t = 0; t < 12; t++) begin
      if (t < N) begin
        bus.in_sel = L'(t); bus.in_valid = 1'b1;
        #1 chk("sweep_in_ready", bus.in_ready, 1'b1);
      end else bus.in_valid = 1'b0;
      cycle();
      if (t + 1 >= L && t + 1 < L + N) begin
        chk("sweep_valid", bus.out_valid, 1'b1);
        chk("sweep_data", bus.out_data, W'(8'h10 + t + 1 - L));
      end else chk("sweep_idle", bus.out_valid, 1'b0);
    end

    // Backpressure: sel 2,3,4 then stall 4 cycles once output is valid
    for (int t = 0; t < 3; t++) begin
      bus.in_sel = L'(2 + t); bus.in_valid = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    chk("bp_first_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("bp_hold_data", bus.out_data, 8'h12);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      #1;
      cycle();
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("bp_drain_valid", bus.out_valid, 1'b1);
      chk("bp_drain_data", bus.out_data, W'(8'h12 + j));
      cycle();
    end
    chk("bp_empty", bus.out_valid, 1'b0);

    // Random valid/ready with simultaneous accept/deliver
    n_in = 0; n_out = 0;
    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'($urandom);
      bus.in_sel    = L'($urandom_range(0, N-1));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (8) cycle();
    chk("rand_count", n_in, n_out);
    chk("rand_queue_empty", q_d.size(), 0);

    // Reset with 3 beats in flight
    bus.out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      bus.in_sel = L'(t + 1); bus.in_valid = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_data", bus.out_data, 8'h00);
    chk("midrst_sel", bus.out_sel, 3'd0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    q_d.delete(); q_s.delete();
    stalled = 0;
    bus.out_ready = 1'b1;
    cycle();
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      chk("postrst_idle", bus.out_valid, 1'b0);
      cycle();
    end

    // Degenerate N=2, WIDTH=16
    bus2.in_data = {16'hBEEF, 16'h1234};
    bus2.in_sel = 1'b1; bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_sel = 1'b0;
    #1;
    chk("n2_valid", bus2.out_valid, 1'b1);
    chk("n2_data_hi", bus2.out_data, 16'hBEEF);
    chk("n2_sel", bus2.out_sel, 1'b1);
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    chk("n2_data_lo", bus2.out_data, 16'h1234);
    @(posedge clk); #1;
    chk("n2_idle", bus2.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
